// File: rtl/anim_pkg.sv
// Shared encodings, frame lengths and pattern lookup for the LED animation sequencer.
package anim_pkg;

    typedef enum logic [1:0] {
        CHASE_L = 2'd0,
        CHASE_R = 2'd1,
        BOUNCE  = 2'd2,
        FILL    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] FRAME_CHASE  = 4'd8;
    localparam logic [3:0] FRAME_BOUNCE = 4'd14;
    localparam logic [3:0] FRAME_FILL   = 4'd9;

    localparam logic [7:0] CHASE_L_START = 8'h01;
    localparam logic [7:0] CHASE_R_START = 8'h80;

    function automatic logic [3:0] frame_last(input mode_e m);
        case (m)
            BOUNCE:  return FRAME_BOUNCE - 4'd1;
            FILL:    return FRAME_FILL - 4'd1;
            default: return FRAME_CHASE - 4'd1;
        endcase
    endfunction

    // LED image for mode m at frame position p; position 0 is the start pattern.
    function automatic logic [7:0] pattern(input mode_e m, input logic [3:0] p);
        logic [3:0] back;
        logic [8:0] fill;
        back = 4'd14 - p;
        fill = (9'd2 << p[2:0]) - 9'd1;
        case (m)
            CHASE_L: return CHASE_L_START << p[2:0];
            CHASE_R: return CHASE_R_START >> p[2:0];
            BOUNCE:  return (p <= 4'd7) ? (CHASE_L_START << p[2:0])
                                        : (CHASE_L_START << back[2:0]);
            default: return (p >= 4'd8) ? 8'h00 : fill[7:0];
        endcase
    endfunction

endpackage

// File: rtl/anim_sequencer_if.sv
// Control/status bundle between the control logic (master) and the sequencer (slave).
interface anim_sequencer_if;
    logic       en;
    logic       halt;
    logic [3:0] speed;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_ready;
    logic [7:0] leds;
    logic       step;
    logic       frame_done;
    logic       busy;

    modport master (
        output en, halt, speed, mode, mode_valid,
        input  mode_ready, leds, step, frame_done, busy
    );

    modport slave (
        input  en, halt, speed, mode, mode_valid,
        output mode_ready, leds, step, frame_done, busy
    );
endinterface

// File: rtl/anim_prescaler.sv
// Two-level step timebase: divides clk by CLK_DIV, then counts ticks up to speed.
module anim_prescaler #(
    parameter int CLK_DIV = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       freeze,
    input  logic [3:0] speed,
    output logic       step_tick
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       spd_q, spd_d;
    logic             tick;

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1)) && !freeze && !clear;
    // Compare with >= so that lowering speed mid-count fires on the next tick.
    assign step_tick = tick && (spd_q >= speed);

    always_comb begin
        div_d = div_q;
        spd_d = spd_q;
        if (clear) begin
            div_d = '0;
            spd_d = '0;
        end else if (tick) begin
            div_d = '0;
            spd_d = step_tick ? 4'd0 : spd_q + 4'd1;
        end else if (!freeze) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            spd_q <= '0;
        end else begin
            div_q <= div_d;
            spd_q <= spd_d;
        end
    end
endmodule

// File: rtl/anim_sequencer.sv
// LED animation sequencer: FSM, one-deep pending mode slot and pattern stepping.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input logic              clk,
    input logic              rst,
    anim_sequencer_if.slave  bus
);
    state_e     state_q, state_d;
    mode_e      mode_q, mode_d, pend_q, pend_d, start_mode;
    logic       pend_vld_q, pend_vld_d;
    logic [3:0] pos_q, pos_d;
    logic [7:0] leds_q, leds_d;
    logic       step_q, step_d, fdone_q, fdone_d;
    logic       ready_q, ready_d, busy_q, busy_d;
    logic       xfer, start, step_tick, clear, freeze;

    assign xfer   = bus.mode_valid && ready_q;
    assign clear  = bus.halt || (state_q == S_IDLE);
    assign freeze = (state_q == S_PAUSE);

    anim_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .freeze    (freeze),
        .speed     (bus.speed),
        .step_tick (step_tick)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        pos_d      = pos_q;
        leds_d     = leds_q;
        step_d     = 1'b0;
        fdone_d    = 1'b0;
        start      = 1'b0;
        start_mode = mode_q;

        if (bus.halt) begin
            state_d    = S_IDLE;
            leds_d     = 8'h00;
            pos_d      = '0;
            pend_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    leds_d = 8'h00;
                    if (xfer && bus.en) begin
                        start      = 1'b1;
                        start_mode = mode_e'(bus.mode);
                    end else if (pend_vld_q && bus.en) begin
                        start      = 1'b1;
                        start_mode = pend_q;
                        pend_vld_d = 1'b0;
                    end else if (xfer) begin
                        pend_d     = mode_e'(bus.mode);
                        pend_vld_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        pend_d     = mode_e'(bus.mode);
                        pend_vld_d = 1'b1;
                    end
                    if (step_tick) begin
                        step_d = 1'b1;
                        // Frame wrap is the only point where a queued mode may take over.
                        if (pos_q == frame_last(mode_q)) begin
                            fdone_d = 1'b1;
                            pos_d   = '0;
                            if (pend_vld_q) begin
                                mode_d     = pend_q;
                                pend_vld_d = 1'b0;
                                leds_d     = pattern(pend_q, 4'd0);
                            end else begin
                                leds_d = pattern(mode_q, 4'd0);
                            end
                        end else begin
                            pos_d  = pos_q + 4'd1;
                            leds_d = pattern(mode_q, pos_q + 4'd1);
                        end
                    end
                    if (!bus.en) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (xfer) begin
                        pend_d     = mode_e'(bus.mode);
                        pend_vld_d = 1'b1;
                    end
                    if (bus.en) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase

            if (start) begin
                state_d = S_RUN;
                mode_d  = start_mode;
                pos_d   = '0;
                leds_d  = pattern(start_mode, 4'd0);
            end
        end

        // Ready drops as soon as the slot fills but rises one cycle after it empties.
        ready_d = bus.halt || !(pend_vld_d || pend_vld_q);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= CHASE_L;
            pend_q     <= CHASE_L;
            pend_vld_q <= 1'b0;
            pos_q      <= '0;
            leds_q     <= 8'h00;
            step_q     <= 1'b0;
            fdone_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pos_q      <= pos_d;
            leds_q     <= leds_d;
            step_q     <= step_d;
            fdone_q    <= fdone_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.leds       = leds_q;
    assign bus.step       = step_q;
    assign bus.frame_done = fdone_q;
    assign bus.mode_ready = ready_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with CLK_DIV=4: vector table plus corner-case sequences.
module tb_anim_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    anim_sequencer_if bus_if ();

    anim_sequencer #(.CLK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       halt;
        logic       mv;
        logic [1:0] mode;
        logic [3:0] speed;
        int         ncyc;
        logic [7:0] leds;
        logic       ready;
        logic       busy;
        logic       step;
        logic       fd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic h, input logic v, input logic [1:0] m,
                       input logic [3:0] s, input int n, input logic [7:0] l,
                       input logic r, input logic b, input logic st, input logic fd);
        vec_t x;
        x.en = e; x.halt = h; x.mv = v; x.mode = m; x.speed = s; x.ncyc = n;
        x.leds = l; x.ready = r; x.busy = b; x.step = st; x.fd = fd;
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] l, input logic r,
                             input logic b, input logic st, input logic fd);
        chk({tag, ".leds"},  bus_if.leds, l);
        chk({tag, ".ready"}, {7'd0, bus_if.mode_ready}, {7'd0, r});
        chk({tag, ".busy"},  {7'd0, bus_if.busy}, {7'd0, b});
        chk({tag, ".step"},  {7'd0, bus_if.step}, {7'd0, st});
        chk({tag, ".fdone"}, {7'd0, bus_if.frame_done}, {7'd0, fd});
    endtask

    task automatic drive(input logic e, input logic h, input logic v, input logic [1:0] m,
                         input logic [3:0] s);
        bus_if.en = e; bus_if.halt = h; bus_if.mode_valid = v; bus_if.mode = m; bus_if.speed = s;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        cyc(3);
        check_all("reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // CHASE_L, speed 0: start pattern next cycle, then a step every 4 cycles
        add(1,0,1,2'd0,4'd0, 1, 8'h01, 1,1,0,0);
        add(1,0,0,2'd0,4'd0, 3, 8'h01, 1,1,0,0);
        add(1,0,0,2'd0,4'd0, 1, 8'h02, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h04, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h08, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h10, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h20, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h40, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h80, 1,1,1,0);
        add(1,0,0,2'd0,4'd0, 4, 8'h01, 1,1,1,1);
        add(1,0,0,2'd0,4'd0, 1, 8'h01, 1,1,0,0);
        // halt with a simultaneous request: request dropped, back to IDLE
        add(1,1,1,2'd3,4'd0, 1, 8'h00, 1,0,0,0);
        add(1,0,0,2'd0,4'd0, 3, 8'h00, 1,0,0,0);
        // BOUNCE, speed 1: step every 8 cycles, 14-step frame
        add(1,0,1,2'd2,4'd1, 1, 8'h01, 1,1,0,0);
        add(1,0,0,2'd0,4'd1, 7, 8'h01, 1,1,0,0);
        add(1,0,0,2'd0,4'd1, 1, 8'h02, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h04, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h08, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h10, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h20, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h40, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h80, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h40, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h20, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h10, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h08, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h04, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h02, 1,1,1,0);
        add(1,0,0,2'd0,4'd1, 8, 8'h01, 1,1,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].halt, tbl[i].mv, tbl[i].mode, tbl[i].speed);
            cyc(tbl[i].ncyc);
            check_all($sformatf("vec%0d", i), tbl[i].leds, tbl[i].ready, tbl[i].busy,
                      tbl[i].step, tbl[i].fd);
        end

        // FILL running, CHASE_R queued at step 3, applied on the FILL wrap
        drive(1, 1, 0, 2'd0, 4'd0); cyc(1);
        drive(1, 0, 1, 2'd3, 4'd0); cyc(1);
        check_all("fill.start", 8'h01, 1, 1, 0, 0);
        drive(1, 0, 0, 2'd0, 4'd0);
        cyc(4); check_all("fill.s1", 8'h03, 1, 1, 1, 0);
        cyc(4); check_all("fill.s2", 8'h07, 1, 1, 1, 0);
        cyc(4); check_all("fill.s3", 8'h0F, 1, 1, 1, 0);
        drive(1, 0, 1, 2'd1, 4'd0); cyc(1);
        check_all("fill.req", 8'h0F, 0, 1, 0, 0);
        drive(1, 0, 1, 2'd0, 4'd0); cyc(3);
        check_all("fill.s4", 8'h1F, 0, 1, 1, 0);
        drive(1, 0, 0, 2'd0, 4'd0);
        cyc(4); check_all("fill.s5", 8'h3F, 0, 1, 1, 0);
        cyc(4); check_all("fill.s6", 8'h7F, 0, 1, 1, 0);
        cyc(4); check_all("fill.s7", 8'hFF, 0, 1, 1, 0);
        cyc(4); check_all("fill.s8", 8'h00, 0, 1, 1, 0);
        cyc(4); check_all("fill.wrap", 8'h80, 0, 1, 1, 1);
        cyc(1); check_all("fill.rdy", 8'h80, 1, 1, 0, 0);
        cyc(3); check_all("chr.s1", 8'h40, 1, 1, 1, 0);

        // en low for 10 cycles mid-step delays the next step by 10 cycles
        drive(1, 1, 0, 2'd0, 4'd0); cyc(1);
        drive(1, 0, 1, 2'd0, 4'd0); cyc(1);
        check_all("pause.start", 8'h01, 1, 1, 0, 0);
        drive(1, 0, 0, 2'd0, 4'd0); cyc(2);
        drive(0, 0, 0, 2'd0, 4'd0);
        cyc(5); check_all("pause.mid", 8'h01, 1, 1, 0, 0);
        cyc(5); check_all("pause.end", 8'h01, 1, 1, 0, 0);
        drive(1, 0, 0, 2'd0, 4'd0);
        cyc(1); check_all("pause.resume", 8'h01, 1, 1, 0, 0);
        cyc(1); check_all("pause.step", 8'h02, 1, 1, 1, 0);

        // async reset mid-frame with the pending slot full
        drive(1, 0, 1, 2'd3, 4'd0); cyc(1);
        check_all("rst.pend", 8'h02, 0, 1, 0, 0);
        drive(1, 0, 0, 2'd0, 4'd0);
        #2 rst = 1'b0;
        #1 check_all("rst.async", 8'h00, 1, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 0, 1, 2'd1, 4'd0); cyc(1);
        check_all("rst.restart", 8'h80, 1, 1, 0, 0);
        drive(1, 0, 0, 2'd0, 4'd0); cyc(4);
        check_all("rst.step", 8'h40, 1, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
